sync_fifo_flags: RTL and testbench
==================================

Name: sync_fifo_flags

Overview:
- Single-clock, parametrised FIFO: configurable width, depth, and almost-full/almost-empty thresholds.
- Adds occupancy count, read-valid strobe, and overflow/underflow error pulses.
- Sits between producer/consumer blocks sharing one clock. Replaces fixed 64x512 buffering wherever flow-control margin or fill level is needed.

Parameters:
- DATA_WIDTH, 64, word width in bits (>=1)
- DEPTH, 512, number of storage words (>=2, any integer, not restricted to power of 2)
- AF_LEVEL, DEPTH-4, o_almost_full asserts when count >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 4, o_almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
- i_clk  input  1  sole clock; all logic on rising edge
- i_rstn  input  1  asynchronous active-low reset
- i_wr_en  input  1  write request
- i_wr_data  input  DATA_WIDTH  write word
- o_full  output  1  count == DEPTH
- o_almost_full  output  1  count >= AF_LEVEL
- o_overflow  output  1  one-cycle pulse: write requested while full
- i_rd_en  input  1  read request
- o_rd_data  output  DATA_WIDTH  read word
- o_rd_valid  output  1  o_rd_data holds a newly read word
- o_empty  output  1  no word available to read
- o_almost_empty  output  1  count <= AE_LEVEL
- o_underflow  output  1  one-cycle pulse: read requested while empty
- o_count  output  $clog2(DEPTH+1)  words held

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rstn is asynchronous, active-low.
- Reset values:
  - Pointers, count, o_rd_data, o_rd_valid, o_overflow, o_underflow = 0
  - o_empty = 1, o_almost_empty = 1, o_full = 0, o_almost_full = 0
  - Memory contents are not reset.
- Reset mid-operation discards all contents immediately; first post-reset edge behaves as empty.
- Acceptance, evaluated on flag values at the clock edge:
  - Write accepted iff i_wr_en && !o_full.
  - Read accepted iff i_rd_en && !o_empty.
- Full with simultaneous rd+wr: read accepted, write rejected, o_overflow pulses; count decrements.
- Empty with simultaneous rd+wr: write accepted, read rejected, o_underflow pulses; count increments.
- Otherwise both accepted together: count unchanged, data order preserved.
- Pointers wrap from DEPTH-1 to 0 explicitly; no reliance on power-of-2 overflow.
- o_count update rule: +1 on write only, -1 on read only, unchanged on both or neither.
- All flags are registered or decoded from registered count only; no combinational path from i_wr_en/i_rd_en to any output.
- Standard-mode read latency: o_rd_data updates and o_rd_valid = 1 on the edge after an accepted read. o_rd_data holds its value when there is no read; o_rd_valid = 0 otherwise.
- Error pulses are not sticky and do not alter pointers or contents.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN (first-word-fall-through).
- Defined:
  - Head word is prefetched into the output register; o_rd_data shows it while !o_empty.
  - o_rd_valid = !o_empty. i_rd_en acts as a pop/acknowledge.
  - Write into an empty FIFO appears on o_rd_data one cycle after the write edge, with o_empty falling.
  - o_count includes the word held in the output register.
- Undefined: standard mode as above, with no prefetch logic.

Decomposition:
- Shared package/header sync_fifo_pkg holds:
  - Pointer-width and count-width constant functions, clog2-based with DEPTH=1 guard
  - Pointer-increment-with-wrap helper
  - Reset-value constants for flags
- One sub-module: fifo_mem_2p. It is a DEPTH x DATA_WIDTH array with one write port and one registered read port, so the array can be swapped for a vendor RAM macro.
- Control (pointers, count, flags, FWFT prefetch) stays in sync_fifo_flags.

Test Plan:
- Reset then write 0x1..0x5 on 5 consecutive cycles, then read 5 -> o_rd_data 0x1..0x5 in order, each 1 cycle after its read; o_count 5->0; o_empty=1 at end.
- Fill DEPTH=8 (AF_LEVEL=6, AE_LEVEL=2) -> o_almost_empty drops at count 3, o_almost_full rises at count 6, o_full at 8. A 9th write -> o_overflow one-cycle pulse, count stays 8, contents unchanged.
- At full, assert rd+wr together -> read returns oldest word, write dropped, o_overflow=1, count 7. At empty, rd+wr -> o_underflow=1, count 1, later read returns the written word.
- DEPTH=5 (non-power-of-2), 3 full fill/drain cycles with continuous simultaneous rd+wr at half-full -> no data loss across pointer wrap 4->0, count constant.
- Assert i_rstn low mid-stream with count=3, asynchronously between edges -> outputs reach reset values without a clock edge; a following read gives o_underflow.
- With SYNC_FIFO_FWFT_EN: write 0xAA to empty -> next cycle o_empty=0, o_rd_valid=1, o_rd_data=0xAA before any i_rd_en. Pop -> o_empty=1, count 0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for sync_fifo_flags.
// Pointer/count width functions, wrap increment, flag reset values.
package sync_fifo_pkg;

    function automatic int ptr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    function automatic int cnt_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth + 1);
    endfunction

    // Explicit wrap so non-power-of-2 depths work.
    function automatic int unsigned ptr_inc(
        input int unsigned ptr,
        input int unsigned depth
    );
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

    localparam logic EMPTY_RST  = 1'b1;
    localparam logic AEMPTY_RST = 1'b1;
    localparam logic FULL_RST   = 1'b0;
    localparam logic AFULL_RST  = 1'b0;

endpackage

// File: rtl/sync_fifo_flags_if.sv
// Producer/consumer bundle for sync_fifo_flags.
// master: drives i_wr_en/i_wr_data/i_rd_en; slave: the FIFO.
interface sync_fifo_flags_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 512
) ();
    localparam int CW = cnt_w(DEPTH);

    logic                  i_wr_en;
    logic [DATA_WIDTH-1:0] i_wr_data;
    logic                  o_full;
    logic                  o_almost_full;
    logic                  o_overflow;
    logic                  i_rd_en;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic                  o_rd_valid;
    logic                  o_empty;
    logic                  o_almost_empty;
    logic                  o_underflow;
    logic [CW-1:0]         o_count;

    modport master (
        output i_wr_en, i_wr_data, i_rd_en,
        input  o_full, o_almost_full, o_overflow,
        input  o_rd_data, o_rd_valid, o_empty,
        input  o_almost_empty, o_underflow, o_count
    );

    modport slave (
        input  i_wr_en, i_wr_data, i_rd_en,
        output o_full, o_almost_full, o_overflow,
        output o_rd_data, o_rd_valid, o_empty,
        output o_almost_empty, o_underflow, o_count
    );
endinterface

// File: rtl/sync_fifo_flags_mem.sv
// fifo_mem_2p: DEPTH x DATA_WIDTH array, one write port, one registered
// read port (clk, rst_n, wr_en/wr_addr/wr_data, rd_en/rd_addr -> rd_data).
module fifo_mem_2p #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 512,
    parameter int AW         = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Output register holds its value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with count, almost flags, rd_valid, error pulses.
// Ports: i_clk, i_rstn (async low), bus (slave). Option: SYNC_FIFO_FWFT_EN.
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 512,
    parameter int AF_LEVEL   = DEPTH - 4,
    parameter int AE_LEVEL   = 4
) (
    input logic              i_clk,
    input logic              i_rstn,
    sync_fifo_flags_if.slave bus
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  pop;
    logic                  vld_q;
    logic                  vld_nxt;
    logic                  full_q;
    logic                  afull_q;
    logic                  empty_q;
    logic                  aempty_q;
    logic                  ovf_q;
    logic                  unf_q;
    logic                  empty_nxt;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    assign wr_acc = bus.i_wr_en && !full_q;

`ifdef SYNC_FIFO_FWFT_EN
    // count includes the prefetched head; mem_cnt is what is left in the
    // array. Refill the head register whenever it is free or being popped.
    logic [CW-1:0] mem_cnt;
    assign pop       = bus.i_rd_en && vld_q;
    assign mem_cnt   = count - CW'(vld_q);
    assign rd_acc    = (mem_cnt != '0) && (!vld_q || pop);
    assign vld_nxt   = rd_acc || (vld_q && !pop);
    assign empty_nxt = !vld_nxt;
`else
    assign pop       = bus.i_rd_en && !empty_q;
    assign rd_acc    = pop;
    assign vld_nxt   = pop;
    assign empty_nxt = (count_nxt == '0);
`endif

    always_comb begin
        count_nxt = count;
        if (wr_acc && !pop)      count_nxt = count + CW'(1);
        else if (!wr_acc && pop) count_nxt = count - CW'(1);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            vld_q    <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            full_q   <= FULL_RST;
            afull_q  <= AFULL_RST;
            empty_q  <= EMPTY_RST;
            aempty_q <= AEMPTY_RST;
        end else begin
            if (wr_acc) wr_ptr <= PW'(ptr_inc(32'(wr_ptr), DEPTH));
            if (rd_acc) rd_ptr <= PW'(ptr_inc(32'(rd_ptr), DEPTH));
            count    <= count_nxt;
            vld_q    <= vld_nxt;
            ovf_q    <= bus.i_wr_en && full_q;
            unf_q    <= bus.i_rd_en && empty_q;
            full_q   <= (count_nxt == DEPTH_C);
            afull_q  <= (count_nxt >= AF_C);
            empty_q  <= empty_nxt;
            aempty_q <= (count_nxt <= AE_C);
        end
    end

    fifo_mem_2p #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .AW        (PW)
    ) u_mem (
        .clk    (i_clk),
        .rst_n  (i_rstn),
        .wr_en  (wr_acc),
        .wr_addr(wr_ptr),
        .wr_data(bus.i_wr_data),
        .rd_en  (rd_acc),
        .rd_addr(rd_ptr),
        .rd_data(mem_rd_data)
    );

    assign bus.o_full         = full_q;
    assign bus.o_almost_full  = afull_q;
    assign bus.o_overflow     = ovf_q;
    assign bus.o_rd_data      = mem_rd_data;
    assign bus.o_rd_valid     = vld_q;
    assign bus.o_empty        = empty_q;
    assign bus.o_almost_empty = aempty_q;
    assign bus.o_underflow    = unf_q;
    assign bus.o_count        = count;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench: DEPTH=8 and DEPTH=5 FIFOs on shared stimulus vs. a queue model.
// Honours SYNC_FIFO_FWFT_EN.
module tb_sync_fifo_flags;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;
    bit         chk_en = 1'b0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    sync_fifo_flags_if #(.DATA_WIDTH(8), .DEPTH(8)) b8 ();
    sync_fifo_flags_if #(.DATA_WIDTH(8), .DEPTH(5)) b5 ();

    assign b8.i_wr_en = wr_en;
    assign b8.i_wr_data = wr_data;
    assign b8.i_rd_en = rd_en;
    assign b5.i_wr_en = wr_en;
    assign b5.i_wr_data = wr_data;
    assign b5.i_rd_en = rd_en;

    sync_fifo_flags #(
        .DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)
    ) u8 (.i_clk(clk), .i_rstn(rst_n), .bus(b8));

    sync_fifo_flags #(
        .DATA_WIDTH(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)
    ) u5 (.i_clk(clk), .i_rstn(rst_n), .bus(b5));

    // Model: k=0 is the DEPTH=8 FIFO, k=1 the DEPTH=5 FIFO.
    int md [2][16];
    int mh [2];
    int mn [2];
    bit vis [2];
    int e_rd [2];
    bit e_val [2];
    bit e_ovf [2];
    bit e_unf [2];

    function automatic int dep(input int k); return k ? 5 : 8; endfunction
    function automatic int afl(input int k); return k ? 4 : 6; endfunction
    function automatic int ael(input int k); return k ? 1 : 2; endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mh[k] = 0; mn[k] = 0; vis[k] = 0;
            e_rd[k] = 0; e_val[k] = 0; e_ovf[k] = 0; e_unf[k] = 0;
        end
    endtask

    task automatic model_pop(input int k, output int v);
        v = md[k][mh[k]];
        mh[k] = (mh[k] + 1) % 16;
        mn[k]--;
    endtask

    task automatic model_push(input int k, input int v);
        md[k][(mh[k] + mn[k]) % 16] = v;
        mn[k]++;
    endtask

    task automatic model_edge(input int k);
        int  v;
        bit  full;
        bit  pop;
        int  memw;
        full = (mn[k] == dep(k));
        e_ovf[k] = wr_en && full;
`ifdef SYNC_FIFO_FWFT_EN
        memw = mn[k] - int'(vis[k]);
        pop = rd_en && vis[k];
        e_unf[k] = rd_en && !vis[k];
        if (pop) model_pop(k, v);
        vis[k] = (vis[k] && !pop) || (memw > 0);
        if (wr_en && !full) model_push(k, int'(wr_data));
        e_val[k] = vis[k];
        if (vis[k]) e_rd[k] = md[k][mh[k]];
`else
        memw = mn[k];
        pop = rd_en && (memw != 0);
        e_unf[k] = rd_en && (memw == 0);
        e_val[k] = pop;
        if (pop) begin
            model_pop(k, v);
            e_rd[k] = v;
        end
        if (wr_en && !full) model_push(k, int'(wr_data));
`endif
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else for (int k = 0; k < 2; k++) model_edge(k);
        end
    end

    task automatic cmp(input int k, input logic [31:0] cnt,
                       input logic emp, input logic ful,
                       input logic af, input logic ae,
                       input logic ovf, input logic unf,
                       input logic val, input logic [7:0] dat);
        string p;
        p = $sformatf("d%0d", dep(k));
        chk({p, " count"}, cnt, mn[k]);
`ifdef SYNC_FIFO_FWFT_EN
        chk({p, " empty"}, emp, !vis[k]);
        if (vis[k]) chk({p, " rd_data"}, dat, e_rd[k]);
`else
        chk({p, " empty"}, emp, mn[k] == 0);
        chk({p, " rd_data"}, dat, e_rd[k]);
`endif
        chk({p, " full"}, ful, mn[k] == dep(k));
        chk({p, " almost_full"}, af, mn[k] >= afl(k));
        chk({p, " almost_empty"}, ae, mn[k] <= ael(k));
        chk({p, " overflow"}, ovf, e_ovf[k]);
        chk({p, " underflow"}, unf, e_unf[k]);
        chk({p, " rd_valid"}, val, e_val[k]);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && chk_en) begin
                cmp(0, 32'(b8.o_count), b8.o_empty, b8.o_full,
                    b8.o_almost_full, b8.o_almost_empty, b8.o_overflow,
                    b8.o_underflow, b8.o_rd_valid, b8.o_rd_data);
                cmp(1, 32'(b5.o_count), b5.o_empty, b5.o_full,
                    b5.o_almost_full, b5.o_almost_empty, b5.o_overflow,
                    b5.o_underflow, b5.o_rd_valid, b5.o_rd_data);
            end
        end
    end

    task automatic step(input bit w, input int d, input bit r);
        wr_en = w;
        wr_data = d[7:0];
        rd_en = r;
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " count"}, 32'(b8.o_count), 0);
        chk({tag, " empty"}, b8.o_empty, 1);
        chk({tag, " almost_empty"}, b8.o_almost_empty, 1);
        chk({tag, " full"}, b8.o_full, 0);
        chk({tag, " almost_full"}, b8.o_almost_full, 0);
        chk({tag, " rd_valid"}, b8.o_rd_valid, 0);
        chk({tag, " rd_data"}, b8.o_rd_data, 0);
        chk({tag, " overflow"}, b8.o_overflow, 0);
        chk({tag, " underflow"}, b8.o_underflow, 0);
        chk({tag, " d5 count"}, 32'(b5.o_count), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dv;
        int w_p;
        int r_p;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        chk_en = 1'b1;

        // In-order write/read of 1..5.
        for (int i = 1; i <= 5; i++) begin
            step(1, i, 0);
            chk("t1 wr count", 32'(b8.o_count), i);
        end
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 1);
            chk("t1 rd count", 32'(b8.o_count), 5 - i);
`ifndef SYNC_FIFO_FWFT_EN
            chk("t1 rd_data", b8.o_rd_data, i);
            chk("t1 rd_valid", b8.o_rd_valid, 1);
`endif
        end
        step(0, 0, 0);
        chk("t1 end empty", b8.o_empty, 1);

        // Fill DEPTH=8 and watch threshold crossings.
        for (int k = 1; k <= 8; k++) begin
            step(1, 'h10 + k, 0);
            chk("t2 count", 32'(b8.o_count), k);
            chk("t2 almost_empty", b8.o_almost_empty, k <= 2);
            chk("t2 almost_full", b8.o_almost_full, k >= 6);
            chk("t2 full", b8.o_full, k == 8);
        end
        step(1, 'h99, 0);
        chk("t2 overflow", b8.o_overflow, 1);
        chk("t2 ovf count", 32'(b8.o_count), 8);
        step(0, 0, 0);
        chk("t2 overflow clr", b8.o_overflow, 0);

        // Full with rd+wr, then drain, then empty with rd+wr.
        step(1, 'hEE, 1);
        chk("t3 full rw overflow", b8.o_overflow, 1);
        chk("t3 full rw count", 32'(b8.o_count), 7);
`ifndef SYNC_FIFO_FWFT_EN
        chk("t3 full rw rd_data", b8.o_rd_data, 'h11);
`endif
        for (int i = 0; i < 7; i++) step(0, 0, 1);
`ifndef SYNC_FIFO_FWFT_EN
        chk("t3 last rd_data", b8.o_rd_data, 'h18);
`endif
        step(1, 'h77, 1);
        chk("t3 empty rw underflow", b8.o_underflow, 1);
        chk("t3 empty rw count", 32'(b8.o_count), 1);
        step(0, 0, 0);
        step(0, 0, 1);
        chk("t3 drain count", 32'(b8.o_count), 0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("t3 rw rd_data", b8.o_rd_data, 'h77);
`endif
        step(0, 0, 0);

        // Non-power-of-2 wrap: fill/drain, then steady rd+wr at 3.
        dv = 'h40;
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 6; j++) begin
                step(1, dv, 0);
                dv++;
            end
            for (int j = 0; j < 6; j++) step(0, 0, 1);
        end
        for (int j = 0; j < 3; j++) begin
            step(1, dv, 0);
            dv++;
        end
        step(0, 0, 0);
        for (int j = 0; j < 30; j++) begin
            step(1, dv, 1);
            dv++;
            chk("t4 d5 steady count", 32'(b5.o_count), 3);
        end
        for (int j = 0; j < 8; j++) step(0, 0, 1);

        // Random traffic, write-heavy then read-heavy.
        for (int j = 0; j < 600; j++) begin
            w_p = (j < 300) ? 70 : 40;
            r_p = (j < 300) ? 40 : 70;
            step($urandom_range(99) < w_p, int'($urandom_range(255)),
                 $urandom_range(99) < r_p);
        end

`ifdef SYNC_FIFO_FWFT_EN
        for (int j = 0; j < 10; j++) step(0, 0, 1);
        step(1, 'hAA, 0);
        step(0, 0, 0);
        chk("fwft empty", b8.o_empty, 0);
        chk("fwft rd_valid", b8.o_rd_valid, 1);
        chk("fwft rd_data", b8.o_rd_data, 'hAA);
        step(0, 0, 1);
        chk("fwft pop empty", b8.o_empty, 1);
        chk("fwft pop count", 32'(b8.o_count), 0);
`endif

        // Async reset between edges with count=3.
        for (int j = 0; j < 10; j++) step(0, 0, 1);
        for (int j = 0; j < 3; j++) step(1, 'hC0 + j, 0);
        step(0, 0, 0);
        chk("t5 pre count", 32'(b8.o_count), 3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async");
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 1);
        chk("t5 post underflow", b8.o_underflow, 1);
        chk("t5 post count", 32'(b8.o_count), 0);
        step(0, 0, 0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
